// File: rtl/abs_sum_window_acc_pkg.sv
// Shared types and width helpers for the windowed abs-sum accumulator and its adder-tree pipeline.
package abs_sum_window_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    function automatic int unsigned pipe_depth(input int unsigned lanes);
        return $clog2(lanes) + 1;
    endfunction

    // Level 0 is the abs stage; each pairwise-add level grows the word by one bit.
    function automatic int unsigned level_w(input int unsigned data_w, input int unsigned k);
        return data_w + 1 + k;
    endfunction

    // Bit offset of level k inside the flattened bus that holds every tree level.
    function automatic int unsigned level_off(input int unsigned lanes, input int unsigned data_w,
                                              input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < k; j++) begin
            off += (lanes >> j) * level_w(data_w, j);
        end
        return off;
    endfunction

endpackage

// File: rtl/abs_sum_tree_pipe.sv
// Registered abs stage followed by a registered pairwise adder tree; a valid bit rides alongside.
module abs_sum_tree_pipe
    import abs_sum_window_acc_pkg::*;
#(
    parameter int unsigned LANES     = 16,
    parameter int unsigned DATA_W    = 8,
    parameter bit          SIGNED_IN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [LANES*DATA_W-1:0]       in_data,
    output logic                          out_valid,
    output logic [DATA_W+$clog2(LANES):0] out_sum
);

    localparam int unsigned LEVELS  = $clog2(LANES);
    localparam int unsigned AW      = level_w(DATA_W, 0);
    localparam int unsigned BUS_W   = level_off(LANES, DATA_W, LEVELS + 1);
    localparam int unsigned OUT_OFF = level_off(LANES, DATA_W, LEVELS);

    logic [BUS_W-1:0]    bus;
    logic [LANES*AW-1:0] abs_q;
    logic [LEVELS:0]     vld_q;

    // One extra bit so the most negative sample maps to its positive magnitude.
    function automatic logic [AW-1:0] abs_of(input logic [DATA_W-1:0] x);
        logic [AW-1:0] e;
        e = {SIGNED_IN & x[DATA_W-1], x};
        return e[AW-1] ? -e : e;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            abs_q[AW*i +: AW] <= abs_of(in_data[DATA_W*i +: DATA_W]);
        end
    end

    assign bus[0 +: LANES*AW] = abs_q;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int unsigned N     = LANES >> k;
        localparam int unsigned W     = level_w(DATA_W, k);
        localparam int unsigned OFF_I = level_off(LANES, DATA_W, k - 1);
        localparam int unsigned OFF_O = level_off(LANES, DATA_W, k);

        logic [N*W-1:0] sum_q;

        always_ff @(posedge clk) begin
            for (int i = 0; i < N; i++) begin
                sum_q[W*i +: W] <= W'(bus[OFF_I + (W-1)*(2*i) +: W-1])
                                 + W'(bus[OFF_I + (W-1)*(2*i+1) +: W-1]);
            end
        end

        assign bus[OFF_O +: N*W] = sum_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LEVELS-1:0], in_valid};
        end
    end

    assign out_valid = vld_q[LEVELS];
    assign out_sum   = bus[OUT_OFF +: level_w(DATA_W, LEVELS)];

endmodule

// File: rtl/abs_sum_window_acc.sv
// Accumulates per-beat abs sums over a fixed window and presents the saturating total on valid/ready.
module abs_sum_window_acc
    import abs_sum_window_acc_pkg::*;
#(
    parameter int unsigned LANES         = 16,
    parameter int unsigned DATA_W        = 8,
    parameter bit          SIGNED_IN     = 1'b1,
    parameter int unsigned ACC_W         = 32,
    parameter int unsigned BEATS_PER_WIN = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_sum,
    output logic                    res_sat
);

    localparam int unsigned TREE_W = level_w(DATA_W, $clog2(LANES));
    localparam int unsigned CNT_W  = $clog2(BEATS_PER_WIN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_WIN - 1);

    logic              flush;
    logic              tree_valid;
    logic [TREE_W-1:0] tree_sum;
    state_e            state;
    logic [ACC_W-1:0]  acc;
    logic              sat_flag;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ACC_W:0]    sum_ext;
    logic              ovf;
    logic [ACC_W-1:0]  acc_next;
    logic              last_beat;

    assign flush    = rst | clr;
    assign in_ready = ~(res_valid & ~res_ready);

    abs_sum_tree_pipe #(
        .LANES     (LANES),
        .DATA_W    (DATA_W),
        .SIGNED_IN (SIGNED_IN)
    ) u_tree (
        .clk       (clk),
        .rst       (flush),
        .in_valid  (in_valid & in_ready),
        .in_data   (in_data),
        .out_valid (tree_valid),
        .out_sum   (tree_sum)
    );

    always_comb begin
        sum_ext   = {1'b0, acc} + (ACC_W+1)'(tree_sum);
        ovf       = sum_ext[ACC_W];
        acc_next  = ovf ? '1 : sum_ext[ACC_W-1:0];
        last_beat = tree_valid && (beat_cnt == LAST_BEAT);
    end

    // A final beat in the same cycle as a result handshake wins: the new result replaces the old.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= ACCUM;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_sat   <= 1'b0;
            acc       <= '0;
            sat_flag  <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (state == HOLD && res_ready) begin
                state     <= ACCUM;
                res_valid <= 1'b0;
            end
            if (tree_valid) begin
                if (last_beat) begin
                    state     <= HOLD;
                    res_valid <= 1'b1;
                    res_sum   <= acc_next;
                    res_sat   <= sat_flag | ovf;
                    acc       <= '0;
                    sat_flag  <= 1'b0;
                    beat_cnt  <= '0;
                end else begin
                    acc      <= acc_next;
                    sat_flag <= sat_flag | ovf;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
